// File: rtl/button_press_solver.sv
// Minimum-press solver: captures one line's target and button masks, walks all
// button subsets in Gray-code order, and sums the per-line minima over the file.
module button_press_solver #(
   parameter int MAX_WIRING_WIDTH = 16,
   parameter int MAX_BUTTONS      = 16,
   parameter int RESULT_WIDTH     = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        end_of_file,
   input  logic                        end_of_line,
   input  logic                        wiring_valid,
   input  logic [MAX_WIRING_WIDTH-1:0] wiring_data,
   output logic                        busy,
   output logic                        result_valid,
   output logic [RESULT_WIDTH-1:0]     result_data,
   output logic                        overflow_error,
   output logic                        unsolvable_error
);

   localparam int CW = $clog2(MAX_BUTTONS + 1);
   // Pop-count width leaves all-ones strictly above any real press count.
   localparam int PW = $clog2(MAX_BUTTONS + 2);
   localparam int IW = (MAX_BUTTONS > 1) ? $clog2(MAX_BUTTONS) : 1;
   localparam int KW = MAX_BUTTONS + 1;
   localparam logic [PW-1:0] INF = {PW{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      ACCUM  = 2'd2
   } state_t;

   function automatic logic [IW-1:0] trailing_zeros(input logic [MAX_BUTTONS-1:0] v);
      trailing_zeros = '0;
      for (int i = MAX_BUTTONS - 1; i >= 0; i--) begin
         if (v[i]) begin
            trailing_zeros = IW'(i);
         end
      end
   endfunction

   logic [MAX_WIRING_WIDTH-1:0] cap_target_r;
   logic [MAX_WIRING_WIDTH-1:0] cap_btn_r [MAX_BUTTONS];
   logic [CW-1:0]               cap_cnt_r;
   logic                        cap_has_r;
   logic                        eof_d_r;

   logic [MAX_WIRING_WIDTH-1:0] nxt_target_s;
   logic [MAX_WIRING_WIDTH-1:0] nxt_btn_s [MAX_BUTTONS];
   logic [CW-1:0]               nxt_cnt_s;
   logic                        nxt_has_s;
   logic                        btn_ovf_s;
   logic                        vld_s;
   logic                        eol_s;
   logic                        eof_rise_s;
   logic                        close_s;

   state_t                      state_r;
   logic [MAX_WIRING_WIDTH-1:0] sol_target_r;
   logic [MAX_WIRING_WIDTH-1:0] sol_btn_r [MAX_BUTTONS];
   logic [CW-1:0]               sol_cnt_r;
   logic [MAX_WIRING_WIDTH-1:0] acc_r;
   logic [MAX_BUTTONS-1:0]      gray_r;
   logic [MAX_BUTTONS-1:0]      k_r;
   logic [PW-1:0]               pop_r;
   logic [PW-1:0]               best_r;
   logic [RESULT_WIDTH-1:0]     total_r;
   logic                        result_valid_r;
   logic [RESULT_WIDTH-1:0]     result_data_r;
   logic                        overflow_r;
   logic                        unsolvable_r;

   logic [IW-1:0]               j_s;
   logic [MAX_WIRING_WIDTH-1:0] acc_n_s;
   logic [MAX_BUTTONS-1:0]      gray_n_s;
   logic [PW-1:0]               pop_n_s;
   logic [KW-1:0]               span_s;
   logic                        last_s;

   assign vld_s      = wiring_valid & ~result_valid_r;
   assign eol_s      = end_of_line & ~result_valid_r;
   assign eof_rise_s = end_of_file & ~eof_d_r;

   // Capture contents including this cycle's valid, so a same-cycle valid joins the closing line.
   always_comb begin
      nxt_target_s = cap_target_r;
      nxt_btn_s    = cap_btn_r;
      nxt_cnt_s    = cap_cnt_r;
      nxt_has_s    = cap_has_r;
      btn_ovf_s    = 1'b0;
      if (vld_s) begin
         if (!cap_has_r) begin
            nxt_target_s = wiring_data;
            nxt_has_s    = 1'b1;
            nxt_cnt_s    = '0;
         end else if (cap_cnt_r < CW'(MAX_BUTTONS)) begin
            nxt_btn_s[cap_cnt_r[IW-1:0]] = wiring_data;
            nxt_cnt_s                    = cap_cnt_r + CW'(1);
         end else begin
            btn_ovf_s = 1'b1;
         end
      end else begin
         btn_ovf_s = 1'b0;
      end
      close_s = nxt_has_s & (eol_s | eof_rise_s);
   end

   // One Gray-code step: flip bit j of the subset, update XOR and press count.
   always_comb begin
      j_s      = trailing_zeros(k_r);
      acc_n_s  = acc_r ^ sol_btn_r[j_s];
      gray_n_s = gray_r ^ (MAX_BUTTONS'(1) << j_s);
      if (gray_n_s[j_s]) begin
         pop_n_s = pop_r + PW'(1);
      end else begin
         pop_n_s = pop_r - PW'(1);
      end
      span_s = (KW'(1) << sol_cnt_r) - KW'(1);
      last_s = (k_r == span_s[MAX_BUTTONS-1:0]);
   end

   // Capture bank register, cleared whenever its line closes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_target_r <= '0;
         cap_cnt_r    <= '0;
         cap_has_r    <= 1'b0;
         eof_d_r      <= 1'b0;
         for (int i = 0; i < MAX_BUTTONS; i++) begin
            cap_btn_r[i] <= '0;
         end
      end else begin
         eof_d_r <= end_of_file;
         if (close_s) begin
            cap_has_r <= 1'b0;
            cap_cnt_r <= '0;
         end else begin
            cap_target_r <= nxt_target_s;
            cap_btn_r    <= nxt_btn_s;
            cap_cnt_r    <= nxt_cnt_s;
            cap_has_r    <= nxt_has_s;
         end
      end
   end

   // Solve FSM: hand-off, subset search, accumulation and completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         sol_target_r   <= '0;
         sol_cnt_r      <= '0;
         acc_r          <= '0;
         gray_r         <= '0;
         k_r            <= '0;
         pop_r          <= '0;
         best_r         <= '0;
         total_r        <= '0;
         result_valid_r <= 1'b0;
         result_data_r  <= '0;
         overflow_r     <= 1'b0;
         unsolvable_r   <= 1'b0;
         for (int i = 0; i < MAX_BUTTONS; i++) begin
            sol_btn_r[i] <= '0;
         end
      end else begin
         if (btn_ovf_s) begin
            overflow_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (close_s) begin
                  sol_target_r <= nxt_target_s;
                  sol_btn_r    <= nxt_btn_s;
                  sol_cnt_r    <= nxt_cnt_s;
                  acc_r        <= '0;
                  gray_r       <= '0;
                  pop_r        <= '0;
                  k_r          <= MAX_BUTTONS'(1);
                  best_r       <= (nxt_target_s == '0) ? PW'(0) : INF;
                  state_r      <= (nxt_cnt_s == '0) ? ACCUM : SEARCH;
               end else if (end_of_file && !nxt_has_s && !result_valid_r) begin
                  result_valid_r <= 1'b1;
                  result_data_r  <= total_r;
               end
            end
            SEARCH: begin
               if (close_s) begin
                  overflow_r <= 1'b1;
               end
               acc_r  <= acc_n_s;
               gray_r <= gray_n_s;
               pop_r  <= pop_n_s;
               k_r    <= k_r + MAX_BUTTONS'(1);
               if (acc_n_s == sol_target_r && pop_n_s < best_r) begin
                  best_r <= pop_n_s;
               end
               if (last_s) begin
                  state_r <= ACCUM;
               end
            end
            ACCUM: begin
               if (close_s) begin
                  overflow_r <= 1'b1;
               end
               if (best_r == INF) begin
                  unsolvable_r <= 1'b1;
               end else begin
                  total_r <= total_r + RESULT_WIDTH'(best_r);
               end
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy             = (state_r != IDLE);
   assign result_valid     = result_valid_r;
   assign result_data      = result_data_r;
   assign overflow_error   = overflow_r;
   assign unsolvable_error = unsolvable_r;

endmodule

// File: tb/tb_button_press_solver.sv
// Self-checking bench for button_press_solver against a brute-force subset model.
module tb_button_press_solver;
   localparam int W  = 16;
   localparam int NB = 16;
   localparam int RW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          end_of_file;
   logic          end_of_line;
   logic          wiring_valid;
   logic [W-1:0]  wiring_data;
   logic          busy;
   logic          result_valid;
   logic [RW-1:0] result_data;
   logic          overflow_error;
   logic          unsolvable_error;

   int checks   = 0;
   int failures = 0;

   button_press_solver #(.MAX_WIRING_WIDTH(W), .MAX_BUTTONS(NB), .RESULT_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .end_of_file(end_of_file), .end_of_line(end_of_line),
      .wiring_valid(wiring_valid), .wiring_data(wiring_data), .busy(busy),
      .result_valid(result_valid), .result_data(result_data),
      .overflow_error(overflow_error), .unsolvable_error(unsolvable_error)
   );

   always #5 clk = ~clk;

   // Reference: exhaustive subset enumeration, -1 when no subset hits the target.
   function automatic int min_presses(input int tgt, input int b[$]);
      int best = -1;
      for (int m = 0; m < (1 << b.size()); m++) begin
         int x = 0;
         int c = 0;
         for (int i = 0; i < b.size(); i++) begin
            if (m[i]) begin
               x = x ^ b[i];
               c++;
            end
         end
         if (x == tgt && (best < 0 || c < best)) best = c;
      end
      return best;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; end_of_file = 1'b0; end_of_line = 1'b0;
      wiring_valid = 1'b0; wiring_data = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send_valid(input int d, input bit with_eol = 1'b0);
      wiring_valid = 1'b1; wiring_data = W'(d); end_of_line = with_eol;
      tick();
      wiring_valid = 1'b0; end_of_line = 1'b0;
   endtask

   task automatic send_eol();
      end_of_line = 1'b1;
      tick();
      end_of_line = 1'b0;
   endtask

   task automatic send_line(input int t, input int b[$], input bit merged, input bit close = 1'b1);
      send_valid(t, merged && close && b.size() == 0);
      for (int i = 0; i < b.size(); i++) send_valid(b[i], merged && close && i == b.size() - 1);
      if (close && !merged) send_eol();
   endtask

   task automatic wait_idle(input int budget, output bit to);
      int n = 0;
      while (busy && n < budget) begin tick(); n++; end
      to = busy;
   endtask

   task automatic finish_file(output bit to);
      int n = 0;
      end_of_file = 1'b1;
      while (!result_valid && n < 200) begin tick(); n++; end
      to = !result_valid;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, result_valid, overflow_error, unsolvable_error, result_data} !== '0) begin
         failures++;
         $display("FAIL reset_state: got busy=%0b rv=%0b ovf=%0b uns=%0b data=%0d, want all 0",
                  busy, result_valid, overflow_error, unsolvable_error, result_data);
      end
   endtask

   task automatic test_examples();
      int l1[$] = '{'h8, 'hA, 'h4, 'hC, 'h5, 'h3};
      int l2[$] = '{'h1D, 'h0C, 'h11, 'h07, 'h1E};
      int l3[$] = '{'h1F, 'h19, 'h37, 'h06};
      bit to;
      do_reset();
      send_line('h6, l1, 1'b0);  repeat (70) tick();
      send_line('h08, l2, 1'b0); repeat (70) tick();
      send_line('h2E, l3, 1'b0); repeat (70) tick();
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(7)) begin
         failures++;
         $display("FAIL examples_total: got rv=%0b data=%0d, want rv=1 data=7", result_valid, result_data);
      end
      checks++;
      if ({overflow_error, unsolvable_error} !== 2'b00) begin
         failures++;
         $display("FAIL examples_flags: got ovf=%0b uns=%0b, want 0 0", overflow_error, unsolvable_error);
      end
      send_line('h1, '{'h1}, 1'b0);
      repeat (5) tick();
      checks++;
      if (busy !== 1'b0 || result_data !== RW'(7)) begin
         failures++;
         $display("FAIL after_done_ignored: got busy=%0b data=%0d, want busy=0 data=7", busy, result_data);
      end
   endtask

   task automatic test_zero_and_unsolvable();
      bit to;
      do_reset();
      send_line('h0, '{'h1, 'h2}, 1'b0);
      wait_idle(40, to);
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(0) || unsolvable_error !== 1'b0) begin
         failures++;
         $display("FAIL zero_target: got rv=%0b data=%0d uns=%0b, want rv=1 data=0 uns=0",
                  result_valid, result_data, unsolvable_error);
      end
      do_reset();
      send_line('h1, '{'h2}, 1'b0);
      wait_idle(40, to);
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(0) || unsolvable_error !== 1'b1) begin
         failures++;
         $display("FAIL unsolvable: got rv=%0b data=%0d uns=%0b, want rv=1 data=0 uns=1",
                  result_valid, result_data, unsolvable_error);
      end
   endtask

   task automatic test_random();
      int b[$];
      int tgt, n, m, sum, expect_uns;
      bit to;
      for (int rep = 0; rep < 3; rep++) begin
         do_reset();
         sum = 0; expect_uns = 0;
         for (int line = 0; line < 6; line++) begin
            n = $urandom_range(0, 8);
            b.delete();
            repeat (n) b.push_back($urandom_range(0, 31));
            tgt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
            m = min_presses(tgt, b);
            if (m < 0) expect_uns = 1; else sum += m;
            send_line(tgt, b, $urandom_range(0, 1) == 1);
            wait_idle(300, to);
            checks++;
            if (to) begin
               failures++;
               $display("FAIL random_line_timeout: got busy=%0b after 300 cycles, want 0", busy);
            end
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 2) == 0) send_eol();
         end
         finish_file(to);
         checks++;
         if (to || result_data !== RW'(sum) || unsolvable_error !== expect_uns[0] || overflow_error !== 1'b0) begin
            failures++;
            $display("FAIL random_total: got rv=%0b data=%0d uns=%0b ovf=%0b, want rv=1 data=%0d uns=%0d ovf=0",
                     result_valid, result_data, unsolvable_error, overflow_error, sum, expect_uns);
         end
      end
   endtask

   task automatic test_drop();
      bit to;
      do_reset();
      send_line('h6, '{'h8, 'hA, 'h4, 'hC, 'h5, 'h3}, 1'b0);
      checks++;
      if (overflow_error !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL drop_pre: got ovf=%0b busy=%0b, want ovf=0 busy=1", overflow_error, busy);
      end
      repeat (10) tick();
      send_line('h1, '{'h1}, 1'b0);
      checks++;
      if (overflow_error !== 1'b1) begin
         failures++;
         $display("FAIL drop_flag: got ovf=%0b, want 1", overflow_error);
      end
      wait_idle(200, to);
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(2)) begin
         failures++;
         $display("FAIL drop_total: got rv=%0b data=%0d, want rv=1 data=2", result_valid, result_data);
      end
   endtask

   task automatic test_button_overflow();
      int b[$];
      int m;
      bit to;
      do_reset();
      for (int i = 0; i < NB; i++) b.push_back(1 << i);
      m = min_presses('h3, b);
      send_line('h3, b, 1'b0, 1'b0);
      checks++;
      if (overflow_error !== 1'b0) begin
         failures++;
         $display("FAIL sixteen_buttons_ok: got ovf=%0b, want 0", overflow_error);
      end
      send_valid('h3);
      checks++;
      if (overflow_error !== 1'b1) begin
         failures++;
         $display("FAIL button_overflow_flag: got ovf=%0b, want 1", overflow_error);
      end
      send_eol();
      wait_idle(70000, to);
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(m) || unsolvable_error !== 1'b0) begin
         failures++;
         $display("FAIL button_overflow_total: got rv=%0b data=%0d uns=%0b, want rv=1 data=%0d uns=0",
                  result_valid, result_data, unsolvable_error, m);
      end
   endtask

   task automatic test_reset_mid_search();
      bit to;
      do_reset();
      send_line('h1, '{'h2}, 1'b0);
      wait_idle(40, to);
      send_line('h6, '{'h8, 'hA, 'h4, 'hC, 'h5, 'h3}, 1'b0);
      repeat (20) tick();
      checks++;
      if (busy !== 1'b1 || unsolvable_error !== 1'b1) begin
         failures++;
         $display("FAIL mid_search_pre: got busy=%0b uns=%0b, want busy=1 uns=1", busy, unsolvable_error);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({busy, result_valid, overflow_error, unsolvable_error, result_data} !== '0) begin
         failures++;
         $display("FAIL mid_search_reset: got busy=%0b rv=%0b ovf=%0b uns=%0b data=%0d, want all 0",
                  busy, result_valid, overflow_error, unsolvable_error, result_data);
      end
      send_line('h6, '{'h8, 'hA, 'h4, 'hC, 'h5, 'h3}, 1'b0);
      wait_idle(200, to);
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(2) || {overflow_error, unsolvable_error} !== 2'b00) begin
         failures++;
         $display("FAIL after_reset_solve: got rv=%0b data=%0d ovf=%0b uns=%0b, want rv=1 data=2 flags 0",
                  result_valid, result_data, overflow_error, unsolvable_error);
      end
   endtask

   task automatic test_no_trailing_lf();
      bit to;
      do_reset();
      send_eol();
      send_eol();
      tick();
      checks++;
      if (busy !== 1'b0 || {overflow_error, unsolvable_error} !== 2'b00) begin
         failures++;
         $display("FAIL blank_eol: got busy=%0b ovf=%0b uns=%0b, want 0 0 0", busy, overflow_error, unsolvable_error);
      end
      send_line('h6, '{'h5, 'h3}, 1'b0, 1'b0);
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL open_line_idle: got busy=%0b, want 0", busy);
      end
      finish_file(to);
      checks++;
      if (to || result_data !== RW'(2) || {overflow_error, unsolvable_error} !== 2'b00) begin
         failures++;
         $display("FAIL eof_close: got rv=%0b data=%0d ovf=%0b uns=%0b, want rv=1 data=2 flags 0",
                  result_valid, result_data, overflow_error, unsolvable_error);
      end
   endtask

   initial begin
      test_reset();
      test_examples();
      test_zero_and_unsolvable();
      test_random();
      test_drop();
      test_reset_mid_search();
      test_no_trailing_lf();
      test_button_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
